// File: rtl/alu_muldiv_pkg.sv
// Shared op/state encodings and op-decode helpers for the iterative RV32M multiply/divide unit.
package alu_muldiv_pkg;

  localparam logic [2:0] MULDIV_OP_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_OP_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_OP_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_OP_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_OP_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_OP_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_OP_REM    = 3'b110;
  localparam logic [2:0] MULDIV_OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // rs1 is signed for everything except the fully unsigned variants
  function automatic logic op_signed_a(input logic [2:0] op);
    return !(op == MULDIV_OP_MULHU || op == MULDIV_OP_DIVU || op == MULDIV_OP_REMU);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return op == MULDIV_OP_MUL || op == MULDIV_OP_MULH ||
           op == MULDIV_OP_DIV || op == MULDIV_OP_REM;
  endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring trial-subtract divide step.
module alu_muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             mode_div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_nxt_c,
  output logic [WIDTH-1:0] lo_nxt_c
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    sum      = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    shifted  = {hi, lo[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    hi_nxt_c = sum[WIDTH:1];
    lo_nxt_c = {sum[0], lo[WIDTH-1:1]};
    // remainder < divisor keeps shifted below 2*divisor, so diff[WIDTH] is a clean borrow
    if (mode_div) begin
      if (!diff[WIDTH]) begin
        hi_nxt_c = diff[WIDTH-1:0];
        lo_nxt_c = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt_c = shifted[WIDTH-1:0];
        lo_nxt_c = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready request and result handshakes.
// Optional ALU_MULDIV_EARLY_OUT_EN: variable-latency early termination, identical results.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_q, neg_d;
  logic             spec_q, spec_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] spec_val;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             calc_exit;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] div_raw, fix_val;

`ifdef ALU_MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0] lz;
  logic [WIDTH-1:0] rem_mask;

  // clamped to WIDTH-1 so a zero dividend still performs one step
  function automatic logic [CNT_W-1:0] lead_zeros(input logic [WIDTH-1:0] x);
    logic [CNT_W-1:0] n;
    logic             found;
    n     = '0;
    found = 1'b0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (!found) begin
        if (x[i]) found = 1'b1;
        else      n = n + CNT_W'(1);
      end
    end
    if (n == CNT_W'(WIDTH)) n = CNT_W'(WIDTH - 1);
    return n;
  endfunction
`endif

  alu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (op_is_div(op_q)),
    .hi       (hi_q),
    .lo       (lo_q),
    .opnd     (opnd_q),
    .hi_nxt_c (step_hi),
    .lo_nxt_c (step_lo)
  );

  // operand decode, magnitudes and special cases seen in IDLE
  always_comb begin
    a_neg    = op_signed_a(op) & a[WIDTH-1];
    b_neg    = op_signed_b(op) & b[WIDTH-1];
    mag_a    = a_neg ? (~a + WIDTH'(1)) : a;
    mag_b    = b_neg ? (~b + WIDTH'(1)) : b;
    div_zero = op_is_div(op) && (b == '0);
    div_ovf  = op_is_div(op) && !op[0] && (a == MOST_NEG) && (b == '1);
    spec_val = '0;
    if (div_zero)     spec_val = op_is_rem(op) ? a : '1;
    else if (div_ovf) spec_val = op_is_rem(op) ? '0 : a;
  end

  // sign correction and half/quotient/remainder select for FIX
  always_comb begin
    prod = {hi_q, lo_q};
`ifdef ALU_MULDIV_EARLY_OUT_EN
    prod = prod >> cnt_q;
`endif
    prod_s  = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
    div_raw = op_is_rem(op_q) ? hi_q : lo_q;
    if (spec_q)                 fix_val = lo_q;
    else if (op_is_div(op_q))   fix_val = neg_q ? (~div_raw + WIDTH'(1)) : div_raw;
    else if (op_q == MULDIV_OP_MUL) fix_val = prod_s[WIDTH-1:0];
    else                        fix_val = prod_s[2*WIDTH-1:WIDTH];
  end

`ifdef ALU_MULDIV_EARLY_OUT_EN
  always_comb begin
    lz        = lead_zeros(mag_a);
    rem_mask  = ~({WIDTH{1'b1}} << cnt_q);
    // multiply can stop once the unconsumed multiplier bits are all zero
    calc_exit = (cnt_q == '0) || (!op_is_div(op_q) && ((lo_q & rem_mask) == '0));
  end
`else
  always_comb calc_exit = (cnt_q == '0);
`endif

  // next-state and datapath control
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    neg_d       = neg_q;
    spec_d      = spec_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d   = op;
          opnd_d = mag_b;
          hi_d   = '0;
          neg_d  = op_is_rem(op) ? a_neg : (a_neg ^ b_neg);
          if (div_zero || div_ovf) begin
            spec_d  = 1'b1;
            lo_d    = spec_val;
            cnt_d   = '0;
            state_d = ST_FIX;
          end else begin
            spec_d  = 1'b0;
            state_d = ST_CALC;
`ifdef ALU_MULDIV_EARLY_OUT_EN
            if (op_is_div(op)) begin
              lo_d  = mag_a << lz;
              cnt_d = CNT_W'(WIDTH) - lz;
            end else begin
              lo_d  = mag_a;
              cnt_d = CNT_W'(WIDTH);
            end
`else
            lo_d  = mag_a;
            cnt_d = CNT_W'(WIDTH);
`endif
          end
        end
      end
      ST_CALC: begin
        if (calc_exit) begin
          state_d = ST_FIX;
        end else begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FIX: begin
        result_d    = fix_val;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      neg_q       <= 1'b0;
      spec_q      <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      opnd_q      <= opnd_d;
      neg_q       <= neg_d;
      spec_q      <= spec_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

endmodule
